srm_controller: RTL and testbench

//  Instruction register, decoder and Moore FSM that sequences the datapath
//  (regfile, A/B/C/status registers, shifter, ALU) for one instruction per

---
 rtl/srm_pkg.sv | 43 ++++
 rtl/srm_if.sv | 37 +++
 rtl/srm_instr_dec.sv | 47 ++++
 rtl/srm_controller.sv | 175 +++++++++++++++++
 tb/tb_srm_controller.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srm_pkg.sv
// Shared encodings for the SRM controller: instruction opcodes, ALU operation
// codes, FSM state and decoded instruction class.
package srm_pkg;

    localparam int SRM_DW = 16;
    localparam int SRM_RW = 3;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_MVN    = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_MOVIMM = 3'd0,
        C_MOVREG = 3'd1,
        C_ADD    = 3'd2,
        C_CMP    = 3'd3,
        C_AND    = 3'd4,
        C_MVN    = 3'd5,
        C_ILL    = 3'd6
    } iclass_e;

endpackage

// File: rtl/srm_if.sv
// Bus between the CPU wrapper/datapath and the SRM controller. The controller
// uses the slave view; the wrapper and datapath side uses the master view.
interface srm_if;
    import srm_pkg::*;

    logic [SRM_DW-1:0] in;
    logic              load;
    logic              s;
    logic              w;
    logic              illegal;
    logic [SRM_RW-1:0] readnum;
    logic [SRM_RW-1:0] writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              vsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [SRM_DW-1:0] datapath_in;

    modport slave (
        input  in, load, s,
        output w, illegal, readnum, writenum, write, loada, loadb, loadc,
               loads, asel, bsel, vsel, shift, ALUop, datapath_in
    );

    modport master (
        output in, load, s,
        input  w, illegal, readnum, writenum, write, loada, loadb, loadc,
               loads, asel, bsel, vsel, shift, ALUop, datapath_in
    );

endinterface

// File: rtl/srm_instr_dec.sv
// Combinational instruction decoder: splits IR into register/shift fields,
// sign-extends imm8 and classifies the instruction.
module srm_instr_dec
    import srm_pkg::*;
#(
    parameter int DW = SRM_DW,
    parameter int RW = SRM_RW
) (
    input  logic [DW-1:0] ir,
    output logic [RW-1:0] rn,
    output logic [RW-1:0] rd,
    output logic [RW-1:0] rm,
    output logic [1:0]    sh,
    output logic [DW-1:0] sximm8,
    output iclass_e       iclass,
    output logic          illegal
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};

    always_comb begin
        iclass = C_ILL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOVIMM)      iclass = C_MOVIMM;
            else if (op == OP_MOVREG) iclass = C_MOVREG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  iclass = C_ADD;
                OP_CMP:  iclass = C_CMP;
                OP_AND:  iclass = C_AND;
                default: iclass = C_MVN;
            endcase
        end
    end

    assign illegal = (iclass == C_ILL);

endmodule

// File: rtl/srm_controller.sv
// SRM controller: instruction register plus a Moore FSM that sequences the
// datapath for one instruction per start pulse. All control outputs are registered.
module srm_controller
    import srm_pkg::*;
#(
    parameter int DW = SRM_DW,
    parameter int RW = SRM_RW
) (
    input  logic  clk,
    input  logic  rst_n,
    srm_if.slave  bus
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic          w_q, w_d;
    logic          illegal_q, illegal_d;
    logic [RW-1:0] readnum_q, readnum_d;
    logic [RW-1:0] writenum_q, writenum_d;
    logic          write_q, write_d;
    logic          loada_q, loada_d;
    logic          loadb_q, loadb_d;
    logic          loadc_q, loadc_d;
    logic          loads_q, loads_d;
    logic          asel_q, asel_d;
    logic          vsel_q, vsel_d;
    logic [1:0]    shift_q, shift_d;
    logic [1:0]    aluop_q, aluop_d;

    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh;
    logic [DW-1:0] sximm8;
    iclass_e       iclass;
    logic          dec_illegal;

    srm_instr_dec #(.DW(DW), .RW(RW)) u_dec (
        .ir      (ir_q),
        .rn      (rn),
        .rd      (rd),
        .rm      (rm),
        .sh      (sh),
        .sximm8  (sximm8),
        .iclass  (iclass),
        .illegal (dec_illegal)
    );

    // A start takes priority over a simultaneous load so the old IR executes.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s)         state_d = S_DECODE;
                else if (bus.load) ir_d    = bus.in;
            end
            S_DECODE: begin
                case (iclass)
                    C_MOVIMM:        state_d = S_WR_IMM;
                    C_MOVREG, C_MVN: state_d = S_GET_B;
                    C_ADD, C_CMP,
                    C_AND:           state_d = S_GET_A;
                    default:         state_d = S_WAIT;
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = (iclass == C_CMP) ? S_WAIT : S_WR_REG;
            default:  state_d = S_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so each state sees them while resident.
    always_comb begin
        w_d        = 1'b0;
        illegal_d  = (state_q == S_DECODE) && dec_illegal;
        readnum_d  = '0;
        writenum_d = '0;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        vsel_d     = 1'b0;
        shift_d    = 2'b00;
        aluop_d    = ALU_ADD;
        case (state_d)
            S_WAIT: w_d = 1'b1;
            S_GET_A: begin
                readnum_d = rn;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm;
                loadb_d   = 1'b1;
            end
            S_EXEC: begin
                shift_d = sh;
                asel_d  = (iclass == C_MOVREG) || (iclass == C_MVN);
                case (iclass)
                    C_CMP:   aluop_d = ALU_SUB;
                    C_AND:   aluop_d = ALU_AND;
                    C_MVN:   aluop_d = ALU_NOT;
                    default: aluop_d = ALU_ADD;
                endcase
                if (iclass == C_CMP) loads_d = 1'b1;
                else                 loadc_d = 1'b1;
            end
            S_WR_REG: begin
                writenum_d = rd;
                write_d    = 1'b1;
            end
            S_WR_IMM: begin
                writenum_d = rn;
                vsel_d     = 1'b1;
                write_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            ir_q       <= '0;
            w_q        <= 1'b1;
            illegal_q  <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            vsel_q     <= 1'b0;
            shift_q    <= 2'b00;
            aluop_q    <= ALU_ADD;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            illegal_q  <= illegal_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            asel_q     <= asel_d;
            vsel_q     <= vsel_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
        end
    end

    assign bus.w           = w_q;
    assign bus.illegal     = illegal_q;
    assign bus.readnum     = readnum_q;
    assign bus.writenum    = writenum_q;
    assign bus.write       = write_q;
    assign bus.loada       = loada_q;
    assign bus.loadb       = loadb_q;
    assign bus.loadc       = loadc_q;
    assign bus.loads       = loads_q;
    assign bus.asel        = asel_q;
    assign bus.bsel        = 1'b0;
    assign bus.vsel        = vsel_q;
    assign bus.shift       = shift_q;
    assign bus.ALUop       = aluop_q;
    assign bus.datapath_in = sximm8;

endmodule

// File: tb/tb_srm_controller.sv
// Bench for srm_controller: controller plus a behavioural datapath, with an
// instruction-level reference model feeding a write scoreboard.
module tb_srm_controller;
    import srm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    srm_if bus();

    srm_controller #(.DW(16), .RW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural datapath
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra = '0, rb = '0, rc = '0;
    logic        z = 1'b0;

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return v;
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    logic [15:0] ain, bin, alu;
    always_comb begin
        ain = bus.asel ? 16'h0000 : ra;
        bin = bus.bsel ? bus.datapath_in : shf(rb, bus.shift);
        case (bus.ALUop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (bus.write) rf[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
        if (bus.loada) ra <= rf[bus.readnum];
        if (bus.loadb) rb <= rf[bus.readnum];
        if (bus.loadc) rc <= alu;
        if (bus.loads) z  <= (alu == 16'h0000);
    end

    // Reference model and scoreboard
    typedef struct {
        logic [2:0]  r;
        logic [15:0] v;
        int          lat;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] ref_r [8] = '{default: 16'h0000};
    logic        ref_z = 1'b0;

    task automatic ref_exec(input logic [15:0] ins);
        logic [2:0]  rn = ins[10:8];
        logic [2:0]  rd = ins[7:5];
        logic [15:0] bv = shf(ref_r[ins[2:0]], ins[4:3]);
        logic [15:0] diff;
        wr_t e;
        case ({ins[15:13], ins[12:11]})
            5'b110_10: begin e.r = rn; e.v = {{8{ins[7]}}, ins[7:0]}; e.lat = 2; end
            5'b110_00: begin e.r = rd; e.v = bv;                      e.lat = 4; end
            5'b101_00: begin e.r = rd; e.v = ref_r[rn] + bv;          e.lat = 5; end
            5'b101_10: begin e.r = rd; e.v = ref_r[rn] & bv;          e.lat = 5; end
            5'b101_11: begin e.r = rd; e.v = ~bv;                     e.lat = 4; end
            5'b101_01: begin
                diff  = ref_r[rn] - bv;
                ref_z = (diff == 16'h0000);
                return;
            end
            default: return;
        endcase
        ref_r[e.r] = e.v;
        sb.push_back(e);
    endtask

    int edge_n = 0;
    int start_edge = 0;
    int loads_edge = 0;
    int wlow_cnt = 0;
    int ill_cnt = 0;
    int en_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_reg", {29'd0, bus.writenum}, {29'd0, e.r});
                    check("wr_val", {16'd0, bus.vsel ? bus.datapath_in : rc}, {16'd0, e.v});
                    if (e.lat > 0) check("wr_lat", edge_n + 1 - start_edge, e.lat);
                end
            end
            if (bus.loads) loads_edge = edge_n + 1;
            if (bus.illegal) ill_cnt++;
            if (bus.loada | bus.loadb | bus.loadc | bus.loads | bus.write) en_cnt++;
            if (!bus.w) wlow_cnt++;
        end
    end

    function automatic logic [15:0] enc_imm(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction
    function automatic logic [15:0] enc_movr(input logic [2:0] rd, input logic [1:0] sh,
                                             input logic [2:0] rm);
        return {3'b110, 2'b00, 3'b000, rd, sh, rm};
    endfunction
    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] rn,
                                            input logic [2:0] rd, input logic [1:0] sh,
                                            input logic [2:0] rm);
        return {3'b101, op, rn, rd, sh, rm};
    endfunction

    task automatic load_ir(input logic [15:0] ins);
        @(negedge clk);
        bus.in   = ins;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.w !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("timeout_w", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic fire();
        bus.s      = 1'b1;
        wlow_cnt   = 0;
        ill_cnt    = 0;
        en_cnt     = 0;
        loads_edge = 0;
        @(posedge clk);
        #1 start_edge = edge_n;
        @(negedge clk);
        bus.s = 1'b0;
        wait_idle();
    endtask

    task automatic check_rf();
        for (int i = 0; i < 8; i++) check("rf", {16'd0, rf[i]}, {16'd0, ref_r[i]});
        check("sb_empty", sb.size(), 32'd0);
    endtask

    task automatic do_instr(input logic [15:0] ins);
        ref_exec(ins);
        load_ir(ins);
        fire();
        check_rf();
    endtask

    initial begin
        int n;
        int snap;
        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_w", {31'd0, bus.w}, 32'd1);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_en", {24'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                         bus.asel, bus.bsel, bus.vsel}, 32'd0);
        check("rst_sel", {22'd0, bus.readnum, bus.writenum, bus.shift, bus.ALUop}, 32'd0);
        check("rst_dpin", {16'd0, bus.datapath_in}, 32'd0);
        rst_n = 1'b1;

        // T1: immediates
        do_instr(enc_imm(3'd0, 8'd7));
        check("t1_wlow", wlow_cnt, 32'd2);
        do_instr(enc_imm(3'd1, 8'hFE));
        check("t1_r1", {16'd0, rf[1]}, 32'h0000FFFE);

        // T2: ADD R2,R0,R1,LSL#1
        do_instr(enc_imm(3'd1, 8'd2));
        do_instr(enc_alu(2'b00, 3'd0, 3'd2, 2'b01, 3'd1));
        check("t2_c", {16'd0, rc}, 32'h0000000B);
        check("t2_r2", {16'd0, rf[2]}, 32'h0000000B);

        // T3: CMP
        do_instr(enc_alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd0));
        check("t3_z_eq", {31'd0, z}, {31'd0, ref_z});
        check("t3_z_one", {31'd0, z}, 32'd1);
        check("t3_loads_lat", loads_edge - start_edge, 32'd4);
        do_instr(enc_alu(2'b01, 3'd0, 3'd5, 2'b00, 3'd1));
        check("t3_z_ne", {31'd0, z}, 32'd0);

        // T4: MVN and shifted MOV
        do_instr(enc_alu(2'b11, 3'd0, 3'd3, 2'b00, 3'd0));
        check("t4_r3", {16'd0, rf[3]}, 32'h0000FFF8);
        do_instr(enc_movr(3'd4, 2'b10, 3'd3));
        check("t4_r4", {16'd0, rf[4]}, 32'h00007FFC);
        do_instr(enc_alu(2'b10, 3'd3, 3'd7, 2'b11, 3'd1));

        // T5: illegal opcode
        do_instr(16'hE000);
        check("t5_ill_pulse", ill_cnt, 32'd1);
        check("t5_no_enables", en_cnt, 32'd0);
        check("t5_wlow", wlow_cnt, 32'd1);

        // load and s together: old IR executes
        ref_exec(enc_imm(3'd5, 8'd3));
        load_ir(enc_imm(3'd5, 8'd3));
        bus.in   = enc_imm(3'd5, 8'd9);
        bus.load = 1'b1;
        fire();
        bus.load = 1'b0;
        check_rf();
        check("ls_r5", {16'd0, rf[5]}, 32'h00000003);

        // s held high re-triggers from WAIT
        load_ir(enc_imm(3'd6, 8'h55));
        ref_exec(enc_imm(3'd6, 8'h55));
        ref_exec(enc_imm(3'd6, 8'h55));
        foreach (sb[i]) sb[i].lat = -1;
        wr_cnt = 0;
        bus.s = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.s = 1'b0;
        wait_idle();
        check("hold_writes", wr_cnt, 32'd2);
        check_rf();

        // T6: reset during GET_B of ADD
        load_ir(enc_alu(2'b00, 3'd0, 3'd2, 2'b01, 3'd1));
        bus.s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s = 1'b0;
        n = 0;
        while (bus.loadb !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_getb", {31'd0, bus.loadb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_w", {31'd0, bus.w}, 32'd1);
        check("t6_loadb", {31'd0, bus.loadb}, 32'd0);
        check("t6_ir", {16'd0, bus.datapath_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        snap = wr_cnt;
        repeat (10) @(negedge clk);
        check("t6_no_write", wr_cnt, snap);
        check("t6_w_after", {31'd0, bus.w}, 32'd1);
        check_rf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
